// File: rtl/regfile.sv
// rtl/regfile.sv - register file: two combinational read ports, one write port, four-phase debug read port
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  typedef enum logic [1:0] {DBG_IDLE, DBG_ACK, DBG_DRAIN} dbg_state_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  dbg_state_e        dbg_state_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_data_q;
  logic [DATA_W-1:0] rdata1_d;
  logic [DATA_W-1:0] rdata2_d;
  logic              write_hit;

  // Register 0 and addresses past NUM_REGS both read as zero.
  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    if (a == '0 || 32'(a) >= NUM_REGS) return '0;
    return regs_q[a];
  endfunction

  assign write_hit = we_i && (waddr_i != '0) && (32'(waddr_i) < NUM_REGS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (write_hit) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_d = '0;
    if (rst_ni && re1_i) begin
      rdata1_d = stored(raddr1_i);
`ifdef REGFILE_BYPASS_EN
      if (write_hit && raddr1_i == waddr_i) rdata1_d = wdata_i;
`endif
    end
  end

  always_comb begin
    rdata2_d = '0;
    if (rst_ni && re2_i) begin
      rdata2_d = stored(raddr2_i);
`ifdef REGFILE_BYPASS_EN
      if (write_hit && raddr2_i == waddr_i) rdata2_d = wdata_i;
`endif
    end
  end

  assign rdata1_o = rdata1_d;
  assign rdata2_o = rdata2_d;

  // Debug snapshot reads the stored array only, so a same-edge write is not seen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbg_state_q <= DBG_IDLE;
      dbg_ack_q   <= 1'b0;
      dbg_data_q  <= '0;
    end else begin
      case (dbg_state_q)
        DBG_IDLE: begin
          if (dbg_req_i) begin
            dbg_data_q  <= stored(dbg_addr_i);
            dbg_ack_q   <= 1'b1;
            dbg_state_q <= DBG_ACK;
          end
        end
        DBG_ACK: begin
          if (!dbg_req_i) begin
            dbg_ack_q   <= 1'b0;
            dbg_state_q <= DBG_DRAIN;
          end
        end
        DBG_DRAIN: begin
          dbg_ack_q   <= 1'b0;
          dbg_state_q <= DBG_IDLE;
        end
        default: begin
          dbg_ack_q   <= 1'b0;
          dbg_state_q <= DBG_IDLE;
        end
      endcase
    end
  end

  assign dbg_ack_o  = dbg_ack_q;
  assign dbg_data_o = dbg_data_q;

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
// Expected values follow both REGFILE_BYPASS_EN builds.
module tb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic        dbg_req_i;
  logic [4:0]  dbg_addr_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_data_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] bypass_exp;

  regfile dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .re1_i      (re1_i),
    .raddr1_i   (raddr1_i),
    .rdata1_o   (rdata1_o),
    .re2_i      (re2_i),
    .raddr2_i   (raddr2_i),
    .rdata2_o   (rdata2_o),
    .dbg_req_i  (dbg_req_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_ack_o  (dbg_ack_o),
    .dbg_data_o (dbg_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b0; raddr2_i = '0;
    dbg_req_i = 1'b0; dbg_addr_i = '0;
    #3;
    chk("reset_ack", {31'b0, dbg_ack_o}, 32'h0);
    chk("reset_rdata1", rdata1_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    re1_i = 1'b0;
    tick();

    // write/read port 1 with enable gating
    wr(5'd5, 32'hDEADBEEF);
    re1_i = 1'b1; raddr1_i = 5'd5; #1;
    chk("rd1_r5", rdata1_o, 32'hDEADBEEF);
    re1_i = 1'b0; #1;
    chk("rd1_disabled", rdata1_o, 32'h0);

    // zero register write dropped
    wr(5'd0, 32'h12345678);
    re2_i = 1'b1; raddr2_i = 5'd0; #1;
    chk("rd2_r0", rdata2_o, 32'h0);

    // same-cycle write/read on r7
    wr(5'd7, 32'h1);
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h2;
    re1_i = 1'b1; raddr1_i = 5'd7; re2_i = 1'b1; raddr2_i = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'h2;
`else
    bypass_exp = 32'h1;
`endif
    chk("same_cycle_rd1", rdata1_o, bypass_exp);
    chk("same_cycle_rd2", rdata2_o, bypass_exp);
    tick();
    we_i = 1'b0; #1;
    chk("after_write_rd1", rdata1_o, 32'h2);
    chk("after_write_rd2", rdata2_o, 32'h2);
    re1_i = 1'b0; re2_i = 1'b0;

    // debug handshake on r31
    wr(5'd31, 32'hCAFE0001);
    dbg_req_i = 1'b1; dbg_addr_i = 5'd31; #1;
    chk("dbg_ack_before_edge", {31'b0, dbg_ack_o}, 32'h0);
    tick();
    chk("dbg_ack_n1", {31'b0, dbg_ack_o}, 32'h1);
    chk("dbg_data_r31", dbg_data_o, 32'hCAFE0001);
    dbg_addr_i = 5'd5;
    tick();
    chk("dbg_ack_held", {31'b0, dbg_ack_o}, 32'h1);
    chk("dbg_data_held", dbg_data_o, 32'hCAFE0001);
    dbg_req_i = 1'b0;
    tick();
    chk("dbg_ack_drop", {31'b0, dbg_ack_o}, 32'h0);
    tick();
    dbg_req_i = 1'b1; dbg_addr_i = 5'd5;
    tick();
    chk("dbg_second_ack", {31'b0, dbg_ack_o}, 32'h1);
    chk("dbg_second_data", dbg_data_o, 32'hDEADBEEF);
    dbg_req_i = 1'b0; tick(); tick();

    // debug read of register 0
    dbg_req_i = 1'b1; dbg_addr_i = 5'd0;
    tick();
    chk("dbg_r0_ack", {31'b0, dbg_ack_o}, 32'h1);
    chk("dbg_r0_data", dbg_data_o, 32'h0);
    dbg_req_i = 1'b0; tick(); tick();

    // debug snapshot ignores a same-edge write
    we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'h11111111;
    dbg_req_i = 1'b1; dbg_addr_i = 5'd5;
    tick();
    we_i = 1'b0;
    re1_i = 1'b1; raddr1_i = 5'd5; #1;
    chk("dbg_no_bypass", dbg_data_o, 32'hDEADBEEF);
    chk("rd1_new_r5", rdata1_o, 32'h11111111);
    dbg_req_i = 1'b0; tick(); tick();

    // reset mid-handshake
    dbg_req_i = 1'b1; dbg_addr_i = 5'd31;
    tick();
    chk("pre_reset_ack", {31'b0, dbg_ack_o}, 32'h1);
    raddr1_i = 5'd31;
    #2 rst_ni = 1'b0;
    #1;
    chk("reset_async_ack", {31'b0, dbg_ack_o}, 32'h0);
    chk("reset_async_data", dbg_data_o, 32'h0);
    chk("reset_async_rd1", rdata1_o, 32'h0);
    dbg_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1_i = 5'(i); #1;
      chk($sformatf("post_reset_r%0d", i), rdata1_o, 32'h0);
    end
    re1_i = 1'b0;
    wr(5'd9, 32'hA5A5A5A5);
    dbg_req_i = 1'b1; dbg_addr_i = 5'd9;
    tick();
    chk("post_reset_dbg_ack", {31'b0, dbg_ack_o}, 32'h1);
    chk("post_reset_dbg_data", dbg_data_o, 32'hA5A5A5A5);
    dbg_req_i = 1'b0; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
